rc4_ksa: RTL and testbench

- RC4 key-scheduling stage. It runs directly upstream of the PRGA stage.
- It takes an S memory already initialised to S[i]=i and permutes it in place using the 24-bit key.
- When rdy returns high, S holds the scheduled state that the PRGA consumes.
- Sequencing is by the top-level controller through the en/rdy handshake; no output data is produced other than the S writes.

---
 rtl/rc4_ksa.sv | 91 +++++++++
 tb/tb_rc4_ksa.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa.sv
// rc4_ksa: RC4 key-scheduling pass that permutes an external S RAM in place.
module rc4_ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren
);
  localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;
  typedef enum logic [2:0] {IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J} state_t;
  state_t                 state_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             i_q, j_q, si_q, kb, j_d;
  logic [KW-1:0]          kidx_q, kidx_d;
  always_comb begin
    kb = '0;
    for (int k = 0; k < KEY_BYTES; k++)
      if (kidx_q == KW'(k)) kb = key_q[8*(KEY_BYTES-1-k) +: 8];
  end
  assign j_d    = j_q + s_rddata + kb;
  assign kidx_d = kidx_q == KW'(KEY_BYTES-1) ? '0 : kidx_q + KW'(1);
  // Outputs are registered, so each transition loads the values the next state presents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rdy      <= 1'b1;
      s_wren   <= 1'b0;
      s_addr   <= '0;
      s_wrdata <= '0;
      i_q      <= '0;
      j_q      <= '0;
      kidx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (en) begin
          key_q   <= key;
          i_q     <= '0;
          j_q     <= '0;
          kidx_q  <= '0;
          rdy     <= 1'b0;
          s_addr  <= '0;
          state_q <= RD_I;
        end
        RD_I: begin
          s_addr  <= i_q;
          state_q <= WT_I;
        end
        WT_I: begin
          si_q    <= s_rddata;
          j_q     <= j_d;
          s_addr  <= j_d;
          state_q <= RD_J;
        end
        RD_J: begin
          s_addr  <= j_q;
          state_q <= WT_J;
        end
        WT_J: begin
          s_addr   <= i_q;
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
          state_q  <= WR_I;
        end
        WR_I: begin
          s_addr   <= j_q;
          s_wrdata <= si_q;
          state_q  <= WR_J;
        end
        WR_J: begin
          s_wren <= 1'b0;
          if (i_q == 8'hFF) begin
            rdy     <= 1'b1;
            state_q <= IDLE;
          end else begin
            i_q     <= i_q + 8'd1;
            s_addr  <= i_q + 8'd1;
            kidx_q  <= kidx_d;
            state_q <= RD_I;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rc4_ksa.sv
// tb_rc4_ksa: directed checks of rc4_ksa against hand-derived traces and a reference KSA.
module tb_rc4_ksa;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [23:0] key = '0;
  logic [7:0]  s_addr, s_rddata, s_wrdata;
  logic        s_wren, rdy;
  logic [7:0]  mem [256];
  logic [7:0]  g [256];
  logic [7:0]  wa [512], wd [512];
  logic        init = 1'b0, clr = 1'b0;
  int          wr_cnt = 0, lowc = 0, checks = 0, failures = 0;

  always #5 clk = ~clk;

  rc4_ksa dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  // Synchronous S RAM plus write log and busy-cycle counter.
  always @(posedge clk) begin
    if (init) for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    else if (s_wren) mem[s_addr] <= s_wrdata;
    s_rddata <= mem[s_addr];
    if (clr) begin
      wr_cnt <= 0;
      lowc   <= 0;
    end else begin
      if (s_wren && wr_cnt < 512) begin
        wa[wr_cnt] <= s_addr;
        wd[wr_cnt] <= s_wrdata;
      end
      if (s_wren) wr_cnt <= wr_cnt + 1;
      if (!rdy) lowc <= lowc + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic gold_ksa(input logic [23:0] k);
    logic [7:0] j, t;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = j + g[i] + 8'(k >> (8 * (2 - i % 3)));
      t = g[i]; g[i] = g[j]; g[j] = t;
    end
  endtask

  task automatic init_s;
    @(negedge clk) init = 1'b1;
    @(negedge clk) init = 1'b0;
    for (int k = 0; k < 256; k++) g[k] = 8'(k);
  endtask

  task automatic start(input logic [23:0] k);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) begin clr = 1'b0; key = k; en = 1'b1; end
    @(negedge clk) en = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    while (!rdy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) chk("timeout", 0, 1);
  endtask

  task automatic cmp_gold(input string tag);
    int bad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== g[k]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic prga_check;
    logic [7:0] s [256];
    logic [7:0] c [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] p [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] ii, jj, t, idx;
    for (int k = 0; k < 256; k++) s[k] = mem[k];
    ii = 0; jj = 0;
    for (int n = 0; n < 9; n++) begin
      ii = ii + 8'd1;
      jj = jj + s[ii];
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      idx = s[ii] + s[jj];
      chk("prga_plain", int'(c[n] ^ s[idx]), int'(p[n]));
    end
  endtask

  initial begin
    int n;
    logic [23:0] keys [4] = '{24'h1A2B3C, 24'hFFFFFF, 24'h000018, 24'h4B6579};
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 1);
    chk("rst_wren", s_wren, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_wrdata", s_wrdata, 0);
    rst = 1'b0;
    // Key 0: counts and hand-derived self-swap / swap trace.
    init_s;
    start(24'h000000);
    wait_done;
    chk("low_cycles", lowc, 1536);
    chk("write_count", wr_cnt, 512);
    chk("k0_w0_addr", wa[0], 0); chk("k0_w0_data", wd[0], 0);
    chk("k0_w1_addr", wa[1], 0); chk("k0_w1_data", wd[1], 0);
    chk("k0_w4_addr", wa[4], 2); chk("k0_w4_data", wd[4], 3);
    chk("k0_w5_addr", wa[5], 3); chk("k0_w5_data", wd[5], 2);
    chk("k0_w6_addr", wa[6], 3); chk("k0_w6_data", wd[6], 5);
    chk("k0_w7_addr", wa[7], 5); chk("k0_w7_data", wd[7], 2);
    gold_ksa(24'h000000);
    cmp_gold("gold_000000");
    // Key 010203: i=0 gives j=1; i=1 reads S[1]=0 so j=1+0+2=3.
    init_s;
    start(24'h010203);
    wait_done;
    chk("k1_w0_addr", wa[0], 0); chk("k1_w0_data", wd[0], 1);
    chk("k1_w1_addr", wa[1], 1); chk("k1_w1_data", wd[1], 0);
    chk("k1_w2_addr", wa[2], 1); chk("k1_w2_data", wd[2], 3);
    chk("k1_w3_addr", wa[3], 3); chk("k1_w3_data", wd[3], 0);
    gold_ksa(24'h010203);
    cmp_gold("gold_010203");
    for (int q = 0; q < 4; q++) begin
      init_s;
      start(keys[q]);
      wait_done;
      gold_ksa(keys[q]);
      cmp_gold($sformatf("gold_%06h", keys[q]));
    end
    prga_check;
    // en and key disturbed mid-run.
    init_s;
    start(24'h123456);
    repeat (98) @(negedge clk);
    key = 24'hABCDEF; en = 1'b1;
    @(negedge clk) en = 1'b0;
    wait_done;
    chk("abuse_low_cycles", lowc, 1536);
    chk("abuse_writes", wr_cnt, 512);
    gold_ksa(24'h123456);
    cmp_gold("abuse_gold");
    // en held high: second run starts on the first idle cycle.
    init_s;
    @(negedge clk) clr = 1'b1;
    @(negedge clk) begin clr = 1'b0; key = 24'h0F1E2D; en = 1'b1; end
    @(negedge clk);
    chk("b2b_accept", rdy, 0);
    wait_done;
    chk("b2b_low_cycles", lowc, 1536);
    @(negedge clk);
    chk("b2b_restart", rdy, 0);
    en = 1'b0;
    wait_done;
    gold_ksa(24'h0F1E2D);
    gold_ksa(24'h0F1E2D);
    cmp_gold("b2b_gold");
    // Reset mid-run.
    init_s;
    start(24'h5A5A5A);
    repeat (697) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_rdy", rdy, 1);
    chk("midrst_wren", s_wren, 0);
    @(negedge clk) rst = 1'b0;
    n = wr_cnt;
    repeat (50) @(negedge clk);
    chk("midrst_no_writes", wr_cnt, n);
    init_s;
    start(24'h5A5A5A);
    wait_done;
    gold_ksa(24'h5A5A5A);
    cmp_gold("midrst_rerun_gold");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
